// File: rtl/regfile_reader.sv
// ---------------------------------------------------------------------------
// regfile_reader
//
// This block holds four 8-bit registers. There is one write port and one
// valid/ready read port, which selects a register by a one-hot code.
//
// Read responses come from a single-entry output register, one cycle after
// the request is accepted. The register can take a new request in the same
// cycle as its response is consumed, so reads run at full throughput.
//
// A read select that is not one-hot produces an error response:
//   - rd_data = 8'h00 and rd_err = 1.
//   - err_count goes up by one, and saturates at 4'hF.
//
// Optional build macro: REGFILE_READER_BYPASS_EN
//   - Defined: a read that is accepted in the same cycle as a write to the
//     same index returns the new wdata.
//   - Undefined (default): such a read returns the value stored before the
//     write.
//
// Ports
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset
//   wr            in   2  write register index
//   write_enable  in   1  write strobe
//   wdata         in   8  write data
//   rd_sel        in   4  one-hot read select
//   rd_valid      in   1  read request valid
//   rd_ready      out  1  read request can be accepted
//   rd_data       out  8  registered read data
//   rd_data_valid out  1  rd_data / rd_err valid
//   rd_data_ready in   1  consumer accepts response
//   rd_err        out  1  response came from a non-one-hot select
//   err_count     out  4  saturating count of accepted errored requests
// ---------------------------------------------------------------------------
module regfile_reader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] wr,
  input  logic       write_enable,
  input  logic [7:0] wdata,
  input  logic [3:0] rd_sel,
  input  logic       rd_valid,
  output logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_data_valid,
  input  logic       rd_data_ready,
  output logic       rd_err,
  output logic [3:0] err_count
);

  logic [7:0] storage_q [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      logic [7:0] value_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg <= 8'h00;
        end else if (write_enable && (wr == 2'(gi))) begin
          value_reg <= wdata;
        end
      end
      assign storage_q[gi] = value_reg;
    end
  endgenerate

  // One-hot decode. Every code other than the four legal ones is an error.
  logic       sel_ok;
  logic [1:0] sel_idx;
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (rd_sel)
      4'b0001: sel_idx = 2'd0;
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  logic [7:0] read_value;
  always_comb begin
    read_value = storage_q[sel_idx];
`ifdef REGFILE_READER_BYPASS_EN
    if (write_enable && (wr == sel_idx)) begin
      read_value = wdata;
    end
`endif
  end

  logic [7:0] rd_data_reg;
  logic       rd_data_valid_reg;
  logic       rd_err_reg;
  logic [3:0] err_count_reg;
  logic       accept;

  // The output register is free when it is empty, or when it is being
  // drained in this same cycle.
  assign rd_ready = !rd_data_valid_reg || rd_data_ready;
  assign accept   = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg       <= 8'h00;
      rd_data_valid_reg <= 1'b0;
      rd_err_reg        <= 1'b0;
      err_count_reg     <= 4'h0;
    end else begin
      if (accept) begin
        rd_data_valid_reg <= 1'b1;
        rd_data_reg       <= sel_ok ? read_value : 8'h00;
        rd_err_reg        <= !sel_ok;
        if (!sel_ok && (err_count_reg != 4'hF)) begin
          err_count_reg <= err_count_reg + 4'd1;
        end
      end else if (rd_data_valid_reg && rd_data_ready) begin
        rd_data_valid_reg <= 1'b0;
      end
    end
  end

  assign rd_data       = rd_data_reg;
  assign rd_data_valid = rd_data_valid_reg;
  assign rd_err        = rd_err_reg;
  assign err_count     = err_count_reg;

endmodule

// File: tb/tb_regfile_reader.sv
// Testbench for regfile_reader. A behavioural model tracks the register
// contents and the single pending response. Directed scenarios run first,
// then randomized traffic with occasional resets.
module tb_regfile_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] wr;
  logic       write_enable;
  logic [7:0] wdata;
  logic [3:0] rd_sel;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_data_valid;
  logic       rd_data_ready;
  logic       rd_err;
  logic [3:0] err_count;

  regfile_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .write_enable (write_enable),
    .wdata        (wdata),
    .rd_sel       (rd_sel),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready),
    .rd_err       (rd_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_mem [4];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_err;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic check_outputs();
    check("rd_data_valid", {31'd0, rd_data_valid}, {31'd0, m_valid});
    check("err_count", {28'd0, err_count}, m_cnt);
    if (m_valid) begin
      check("rd_data", {24'd0, rd_data}, {24'd0, m_data});
      check("rd_err", {31'd0, rd_err}, {31'd0, m_err});
    end
  endtask

  // One clock cycle of stimulus, with the model updated at the edge.
  task automatic cycle(input logic we_i, input logic [1:0] wr_i, input logic [7:0] wd_i,
                       input logic rv_i, input logic [3:0] sel_i, input logic dr_i);
    logic       exp_ready;
    logic [7:0] d;
    int         k;
    @(negedge clk);
    write_enable  = we_i;
    wr            = wr_i;
    wdata         = wd_i;
    rd_valid      = rv_i;
    rd_sel        = sel_i;
    rd_data_ready = dr_i;
    exp_ready = !m_valid || dr_i;
    #1;
    check("rd_ready", {31'd0, rd_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (rv_i && exp_ready) begin
      if ($countones(sel_i) == 1) begin
        k = 0;
        for (int b = 0; b < 4; b++) if (sel_i[b]) k = b;
        d = m_mem[k];
`ifdef REGFILE_READER_BYPASS_EN
        if (we_i && (int'(wr_i) == k)) d = wd_i;
`endif
        m_data = d;
        m_err  = 1'b0;
      end else begin
        m_data = 8'h00;
        m_err  = 1'b1;
        if (m_cnt < 15) m_cnt++;
      end
      m_valid = 1'b1;
    end else if (m_valid && dr_i) begin
      m_valid = 1'b0;
    end
    if (we_i) m_mem[wr_i] = wd_i;
    #1;
    check_outputs();
  endtask

  // Asserts reset mid-cycle while a write is attempted, then releases it.
  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    write_enable  = 1'b1;
    wr            = 2'($urandom_range(0, 3));
    wdata         = 8'($urandom);
    rd_valid      = 1'b1;
    rd_sel        = 4'b0001;
    rd_data_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", {31'd0, rd_data_valid}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'd0);
    check("rst_err", {31'd0, rd_err}, 32'd0);
    check("rst_cnt", {28'd0, err_count}, 32'd0);
    check("rst_ready", {31'd0, rd_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n        = 1'b1;
    write_enable = 1'b0;
    rd_valid     = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, rd_ready}, 32'd1);
    check("post_rst_valid", {31'd0, rd_data_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    write_enable = 1'b0; wr = 2'd0; wdata = 8'h00;
    rd_valid = 1'b0; rd_sel = 4'b0000; rd_data_ready = 1'b1;
    model_reset();
    do_reset();

    // Write A5 to index 2, then read it back.
    cycle(1'b1, 2'd2, 8'hA5, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 4'b0100, 1'b1);
    check("a5_data", {24'd0, rd_data}, 32'h0000_00A5);
    check("a5_err", {31'd0, rd_err}, 32'd0);

    // Same-cycle write and read of index 1.
    cycle(1'b1, 2'd1, 8'h11, 1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 2'd1, 8'h3C, 1'b1, 4'b0010, 1'b1);
`ifdef REGFILE_READER_BYPASS_EN
    check("bypass_data", {24'd0, rd_data}, 32'h0000_003C);
`else
    check("nobypass_data", {24'd0, rd_data}, 32'h0000_0011);
`endif

    // A non-one-hot select, then saturation of err_count.
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 4'b0110, 1'b1);
    check("err_flag", {31'd0, rd_err}, 32'd1);
    check("err_zero", {24'd0, rd_data}, 32'd0);
    check("err_cnt1", {28'd0, err_count}, 32'd1);
    for (int i = 0; i < 17; i++) cycle(1'b0, 2'd0, 8'h00, 1'b1, 4'b0000, 1'b1);
    check("err_sat", {28'd0, err_count}, 32'd15);

    // Hold the response while stalled, even when its source register is written.
    cycle(1'b1, 2'd3, 8'h5A, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd3, 8'hFF, 1'b1, 4'b1000, 1'b0);
      check("hold_data", {24'd0, rd_data}, 32'h0000_005A);
      check("hold_ready", {31'd0, rd_ready}, 32'd0);
      check("hold_valid", {31'd0, rd_data_valid}, 32'd1);
    end
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b1);

    // Back-to-back reads of all four indices.
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 8'(8'h10 + i), 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0, 8'h00, 1'b1, 4'(1 << i), 1'b1);
      check("b2b_data", {24'd0, rd_data}, 32'h10 + i);
      check("b2b_ready", {31'd0, rd_ready}, 32'd1);
    end

    // Reset while a response is pending; all registers then read back zero.
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 4'b0001, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0, 8'h00, 1'b1, 4'(1 << i), 1'b1);
      check("rst_mem", {24'd0, rd_data}, 32'd0);
    end
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] sel;
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 9) < 7) sel = 4'(1 << $urandom_range(0, 3));
      else sel = 4'($urandom);
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 3) != 0), sel, 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
